// File: rtl/digit_scanner.sv
// rtl/digit_scanner.sv - time-multiplexed 4-digit 7-segment scan driver with blanking and dead time
module digit_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] blank_mask,
    input  logic [3:0] dp_in,
    output logic [3:0] sel,
    output logic [1:0] digit_idx,
    output logic [3:0] an,
    output logic       dp_n,
    output logic       tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic          sel_onehot;
    logic          dark;
    logic          selected_lit;

    // A corrupted select is repaired at the next rotation rather than propagated.
    assign sel_onehot = (sel != 4'b0000) && ((sel & (sel - 4'b0001)) == 4'b0000);

    // Slot prescaler, select rotation and slot-start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            sel  <= 4'b1000;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                sel  <= sel_onehot ? {sel[0], sel[3:1]} : 4'b1000;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    // Binary index of the active digit.
    always_comb begin
        digit_idx = 2'd0;
        case (sel)
            4'b1000: digit_idx = 2'd3;
            4'b0100: digit_idx = 2'd2;
            4'b0010: digit_idx = 2'd1;
            4'b0001: digit_idx = 2'd0;
            default: digit_idx = 2'd0;
        endcase
    end

    // Anode and decimal-point drive; dead time at slot start hides mux/decoder settling.
    always_comb begin
        dark         = rst | ~en | (cnt < CNT_BLANK);
        an           = dark ? 4'b1111 : ~(sel & ~blank_mask);
        selected_lit = |(~an & sel);
        dp_n         = selected_lit ? ~|(dp_in & sel) : 1'b1;
    end

endmodule

// File: tb/tb_digit_scanner.sv
// tb/tb_digit_scanner.sv - randomized self-checking bench for digit_scanner against a frame-arithmetic model
module tb_digit_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] blank_mask = 4'b0000;
    logic [3:0] dp_in = 4'b0000;

    logic [3:0] sel_a, an_a, sel_b, an_b;
    logic [1:0] idx_a, idx_b;
    logic       dp_n_a, tick_a, dp_n_b, tick_b;

    int checks = 0;
    int errors = 0;

    // Model state: enabled edges since the last reset, and whether the last edge advanced.
    int e = 0;
    bit last_adv = 1'b0;
    bit valid = 1'b0;

    always #5 clk = ~clk;

    digit_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .blank_mask(blank_mask), .dp_in(dp_in),
        .sel(sel_a), .digit_idx(idx_a), .an(an_a), .dp_n(dp_n_a), .tick(tick_a)
    );

    digit_scanner #(.REFRESH_DIV(1), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .blank_mask(blank_mask), .dp_in(dp_in),
        .sel(sel_b), .digit_idx(idx_b), .an(an_b), .dp_n(dp_n_b), .tick(tick_b)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs from frame position: which digit is up and how far into its slot.
    task automatic check_dut(input string p, input int div, input int blank,
                             input logic [3:0] s, input logic [1:0] di, input logic [3:0] a,
                             input logic d, input logic t);
        int pos, phase;
        bit dark, lit;
        logic [3:0] exp_sel, exp_an;
        pos     = 3 - ((e / div) % 4);
        phase   = e % div;
        exp_sel = 4'(1 << pos);
        dark    = rst || !en || (phase < blank);
        exp_an  = 4'b1111;
        if (!dark) exp_an[pos] = blank_mask[pos];
        lit     = !dark && !blank_mask[pos];
        if (valid) begin
            check({p, "_sel"}, 8'(s), 8'(exp_sel));
            check({p, "_idx"}, 8'(di), 8'(pos));
            check({p, "_tick"}, 8'(t), 8'(last_adv && (e % div == 0)));
            check({p, "_dp_n"}, 8'(d), 8'(lit ? !dp_in[pos] : 1'b1));
        end
        check({p, "_an"}, 8'(a), 8'(valid ? exp_an : 4'b1111));
    endtask

    // One clock: drive inputs, check on the falling edge, then advance the model at the rising edge.
    task automatic step(input logic r, input logic n, input logic [3:0] m, input logic [3:0] dp);
        #1;
        rst = r; en = n; blank_mask = m; dp_in = dp;
        @(negedge clk);
        check_dut("a", 4, 1, sel_a, idx_a, an_a, dp_n_a, tick_a);
        check_dut("b", 1, 0, sel_b, idx_b, an_b, dp_n_b, tick_b);
        @(posedge clk);
        if (rst) begin
            e = 0; last_adv = 1'b0; valid = 1'b1;
        end else if (en) begin
            e++; last_adv = 1'b1;
        end else begin
            last_adv = 1'b0;
        end
    endtask

    initial begin
        @(posedge clk);
        // Reset, then a plain scan over several frames.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4'b0000, 4'b0000);
        // Freeze mid-slot at cnt=2, then resume.
        for (int i = 0; i < 8 && (e % 4) != 2; i++) step(1'b0, 1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 4'b0000, 4'b0000);
        // Blank digit 2 for a full frame.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'b0100, 4'b0000);
        // Decimal point on digit 1 only.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'b0000, 4'b0010);
        // Reset mid-slot while sel=0010, cnt=2.
        for (int i = 0; i < 20 && !(((e / 4) % 4) == 2 && (e % 4) == 2); i++)
            step(1'b0, 1'b1, 4'b0000, 4'b0010);
        step(1'b1, 1'b1, 4'b0000, 4'b0010);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 4'b0000, 4'b0010);
        // Randomized enables, masks, decimal points and occasional resets.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 6) != 0),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
